dq_result_buffer: RTL and testbench

Credit-managed elastic output buffer that sits directly downstream of a `dq` fixed-latency delay line. `dq` has no stall and no reset, so this block works out when the producer may inject items. It captures the delayed data and valid as they emerge and presents them to a stalling consumer through a valid/ready port. No item is dropped while the producer honours `issue_ready`.

---
 rtl/dq_result_buffer_if.sv | 32 +++
 rtl/dq_result_buffer.sv | 124 ++++++++++++
 tb/tb_dq_result_buffer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dq_result_buffer_if.sv
// Handshake bundle between a dq-fed producer, the result buffer and its consumer.
interface dq_result_buffer_if #(
    parameter int WIDTH = 8
) ();
    logic             issue_valid;
    logic             issue_ready;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output issue_valid,
        input  issue_ready,
        output in_valid,
        output in_data,
        input  out_valid,
        output out_ready,
        input  out_data
    );

    modport slave (
        input  issue_valid,
        output issue_ready,
        input  in_valid,
        input  in_data,
        output out_valid,
        input  out_ready,
        output out_data
    );
endinterface

// File: rtl/dq_result_buffer.sv
// Credit-managed elastic buffer behind an unresettable fixed-latency dq line.
module dq_result_buffer #(
    parameter int WIDTH = 8,
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    dq_result_buffer_if.slave          bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_P = PW'(DEPTH - 1);
    localparam logic [FW-1:0] LAST_F = FW'(LAT - 1);

    typedef enum logic {
        FLUSH,
        RUN
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [FW-1:0]   flush_cnt;
    logic [FW-1:0]   flush_nxt;
    logic [CW-1:0]   reserved;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    logic run;
    logic issue;
    logic pop;
    logic push;
    logic ovf_set;

    function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + 1'b1;
    endfunction

    // Flush masks the stale valids still draining out of dq after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FLUSH;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        flush_nxt = flush_cnt;
        unique case (state)
            FLUSH: begin
                if (flush_cnt == LAST_F) begin
                    state_nxt = RUN;
                    flush_nxt = '0;
                end else begin
                    flush_nxt = flush_cnt + 1'b1;
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
        endcase
    end

    assign run             = (state == RUN);
    assign bus.issue_ready = run && (reserved < FULL);
    assign bus.out_valid   = (count != '0);
    assign bus.out_data    = bus.out_valid ? mem[rd_ptr] : '0;

    assign issue   = bus.issue_valid & bus.issue_ready;
    assign pop     = bus.out_valid & bus.out_ready;
    assign push    = bus.in_valid & run & (count < FULL);
    assign ovf_set = (bus.issue_valid & ~bus.issue_ready)
                   | (bus.in_valid & run & (count == FULL));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reserved <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= nxt_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= nxt_ptr(rd_ptr);
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Guarded so unreserved pushes cannot wrap the credit count.
            unique case (1'b1)
                issue && !pop:
                    reserved <= reserved + 1'b1;
                pop && !issue && (reserved != '0):
                    reserved <= reserved - 1'b1;
                default:
                    reserved <= reserved;
            endcase
            if (ovf_set) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dq_result_buffer.sv
// Scoreboard bench: random and directed traffic through a dq model.
module tb_dq_result_buffer;
    localparam int W   = 8;
    localparam int LAT = 2;
    localparam int D   = 4;
    localparam int D3  = 3;

    typedef struct {
        logic [W-1:0] d;
        int           c;
    } item_t;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst3 = 1'b1;
    always #5 clk = ~clk;

    dq_result_buffer_if #(.WIDTH(W)) b ();
    dq_result_buffer_if #(.WIDTH(W)) b3 ();

    logic [$clog2(D+1)-1:0]  cnt;
    logic                    ovf;
    logic [$clog2(D3+1)-1:0] cnt3;
    logic                    ovf3;

    dq_result_buffer #(.WIDTH(W), .LAT(LAT), .DEPTH(D)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (b),
        .count    (cnt),
        .overflow (ovf)
    );

    dq_result_buffer #(.WIDTH(W), .LAT(LAT), .DEPTH(D3)) u_dut3 (
        .clk      (clk),
        .rst      (rst3),
        .bus      (b3),
        .count    (cnt3),
        .overflow (ovf3)
    );

    logic         pv  [LAT];
    logic         pv3 [LAT];
    logic [W-1:0] pd  [LAT];
    logic [W-1:0] pd3 [LAT];
    logic         inj, inj3, force_v;
    logic [W-1:0] iss_d, iss_d3, force_d;

    // Behavioural dq: plain delay line, no reset, no stall.
    always @(posedge clk) begin
        pv[0]  <= inj;
        pd[0]  <= iss_d;
        pv3[0] <= inj3;
        pd3[0] <= iss_d3;
        for (int i = 1; i < LAT; i++) begin
            pv[i]  <= pv[i-1];
            pd[i]  <= pd[i-1];
            pv3[i] <= pv3[i-1];
            pd3[i] <= pd3[i-1];
        end
    end

    assign b.in_valid  = pv[LAT-1] | force_v;
    assign b.in_data   = force_v ? force_d : pd[LAT-1];
    assign b3.in_valid = pv3[LAT-1];
    assign b3.in_data  = pd3[LAT-1];

    item_t        q[$];
    logic [W-1:0] q3[$];
    int  cyc, since, n_vec, n_bad;
    bit  stream, exp_ovf, done3;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic int landed();
        int n = 0;
        foreach (q[i]) if (q[i].c + LAT < cyc) n++;
        return n;
    endfunction

    task automatic tick(input bit want, input bit rdy,
                        input logic [W-1:0] d,
                        input bit frc, input bit bad);
        int l;
        @(negedge clk);
        cyc++;
        since++;
        rst     = 1'b0;
        force_v = 1'b0;
        inj     = 1'b0;
        l = landed();
        chk("issue_ready", b.issue_ready, int'(since > LAT && q.size() < D));
        chk("count", cnt, l);
        chk("out_valid", b.out_valid, int'(l != 0));
        chk("out_data", b.out_data, (l != 0) ? int'(q[0].d) : 0);
        chk("overflow", ovf, exp_ovf);
        b.out_ready = rdy;
        iss_d   = d;
        force_d = d;
        if (bad) begin
            b.issue_valid = 1'b1;
            if (!b.issue_ready) exp_ovf = 1'b1;
            else inj = 1'b1;
        end else begin
            b.issue_valid = want & b.issue_ready;
            inj = b.issue_valid;
        end
        if (inj) q.push_back('{d, cyc});
        if (frc) begin
            force_v = 1'b1;
            if (since > LAT && l == D) exp_ovf = 1'b1;
        end
    endtask

    task automatic do_reset(input bit frc, input bit inj_in,
                            input logic [W-1:0] d);
        @(negedge clk);
        cyc++;
        rst           = 1'b1;
        b.issue_valid = 1'b0;
        b.out_ready   = 1'b0;
        inj           = inj_in;
        iss_d         = d;
        force_v       = frc;
        force_d       = d;
        q.delete();
        exp_ovf = 1'b0;
        since   = 0;
    endtask

    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            #2;
            if (b.out_valid && b.out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_pop", b.out_data, -1);
                end else begin
                    it = q.pop_front();
                    chk("pop_data", b.out_data, it.d);
                    if (stream) chk("latency", cyc - it.c, LAT + 1);
                end
            end
        end
    end

    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (b3.out_valid && b3.out_ready) begin
                if (q3.size() == 0) begin
                    chk("wrap_spurious", b3.out_data, -1);
                end else begin
                    e = q3.pop_front();
                    chk("wrap_data", b3.out_data, e);
                end
            end
        end
    end

    // DEPTH=3 instance exercises non-power-of-two pointer wrap.
    initial begin
        b3.issue_valid = 1'b0;
        b3.out_ready   = 1'b0;
        inj3   = 1'b0;
        iss_d3 = '0;
        done3  = 1'b0;
        repeat (3) @(negedge clk);
        rst3 = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            b3.out_ready = ($urandom_range(0, 9) < 6);
            iss_d3 = 8'($urandom);
            inj3   = b3.issue_ready && ($urandom_range(0, 3) != 0);
            b3.issue_valid = inj3;
            if (inj3) q3.push_back(iss_d3);
        end
        @(negedge clk);
        b3.issue_valid = 1'b0;
        inj3 = 1'b0;
        b3.out_ready = 1'b1;
        repeat (12) @(negedge clk);
        chk("wrap_drain", q3.size(), 0);
        chk("wrap_overflow", ovf3, 0);
        done3 = 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < LAT; i++) begin
            pv[i]  = 1'b0;
            pv3[i] = 1'b0;
            pd[i]  = '0;
            pd3[i] = '0;
        end
        b.issue_valid = 1'b0;
        b.out_ready   = 1'b0;
        inj = 1'b0;
        iss_d = '0;
        force_v = 1'b0;
        force_d = '0;
        cyc = 0;
        since = 0;
        n_vec = 0;
        n_bad = 0;
        stream = 1'b0;
        exp_ovf = 1'b0;

        // Reset and flush with junk valids on the input.
        do_reset(1'b1, 1'b0, 8'h5A);
        repeat (LAT) tick(1'b1, 1'b0, 8'($urandom), 1'b1, 1'b0);
        repeat (3) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Streaming with consumer always ready.
        stream = 1'b1;
        for (int i = 1; i <= 8; i++) tick(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
        repeat (LAT + 2) tick(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        stream = 1'b0;

        // Backpressure until full, single pop, then drain.
        repeat (8) tick(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
        tick(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
        repeat (12) tick(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

        // Issue and pop together with three reserved.
        repeat (3) tick(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
        repeat (LAT + 1) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
        repeat (LAT + 1) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (8) tick(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

        // Push and pop together with two stored.
        repeat (2) tick(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
        repeat (LAT + 1) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
        repeat (LAT - 1) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (8) tick(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

        // Violations: unreserved input when full, issue while not ready.
        repeat (4) tick(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
        repeat (LAT + 1) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 8'hAA, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 8'($urandom), 1'b0, 1'b1);
        repeat (3) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (10) tick(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

        // Reset with three stored and two in flight.
        repeat (3) tick(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
        repeat (LAT + 1) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
        do_reset(1'b0, 1'b1, 8'h77);
        repeat (LAT + 3) tick(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            tick($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                 8'($urandom), 1'b0, 1'b0);
        end
        for (int i = 0; i < 40 && q.size() != 0; i++) begin
            tick(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        end
        chk("drain", q.size(), 0);

        for (int i = 0; i < 2000 && !done3; i++) @(negedge clk);
        chk("wrap_done", done3, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
